reset_sequencer: RTL

Parametrised reset synchroniser and sequencer for one clock domain. An asynchronous board reset asserts all outputs immediately. After the reset is removed and synchronised, the block holds reset for a minimum time, then releases NUM_OUTS reset outputs one at a time in index order. A synchronous soft-reset request re-runs the same sequence without a board reset. It sits at the top of each board wrapper and feeds core, video and audio resets.

---
 rtl/reset_seq_pkg.sv | 27 ++
 rtl/reset_sequencer_sync.sv | 22 ++
 rtl/reset_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  // The down-counter must hold HOLD_CYCLES-1 and STEP_CYCLES-1; the floor of 2 keeps it at least 1 bit wide.
  function automatic int cnt_width(input int hold_cycles, input int step_cycles);
    int m;
    m = 2;
    if (hold_cycles > m) m = hold_cycles;
    if (step_cycles > m) m = step_cycles;
    return $clog2(m);
  endfunction

  function automatic bit params_legal(input int sync_stages, input int num_outs,
                                      input int hold_cycles, input int step_cycles);
    return (sync_stages >= 2) && (sync_stages <= 4) &&
           (num_outs >= 1) && (num_outs <= 8) &&
           (hold_cycles >= 0) && (step_cycles >= 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Reset synchroniser: asynchronous assert, synchronous deassert through SYNC_STAGES flops.
module reset_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  output logic out
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all resets after a synchronised board or soft reset, then releases them in index order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUTS    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                soft_req,
  output logic [NUM_OUTS-1:0] out,
  output logic                ready
);

  localparam int CW = cnt_width(HOLD_CYCLES, STEP_CYCLES);
  localparam int IW = $clog2(NUM_OUTS + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CW-1:0] STEP_LOAD = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_OUTS - 1);

  if (!params_legal(SYNC_STAGES, NUM_OUTS, HOLD_CYCLES, STEP_CYCLES)) begin : g_bad_params
    $error("reset_sequencer: parameter out of legal range");
  end

  logic                sync_rst;
  logic                rst_req;
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                release0;
  logic [NUM_OUTS-1:0] out_q, out_d;
  logic                ready_q, ready_d;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .out   (sync_rst)
  );

  assign rst_req = sync_rst | soft_req;

  // Outputs are registered next to the state so they never glitch on a decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    release0 = 1'b0;
    if (rst_req) begin
      state_d = ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ASSERT: begin
          if (HOLD_CYCLES > 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            release0 = 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == '0) release0 = 1'b1;
          else             cnt_d = cnt_q - CW'(1);
        end
        RELEASE: begin
          if (cnt_q == '0) begin
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
            end else begin
              cnt_d = STEP_LOAD;
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        RUN:     state_d = RUN;
        default: state_d = ASSERT;
      endcase
      // out[0] release is shared by the HOLD terminal count and the zero-hold ASSERT exit.
      if (release0) begin
        if (NUM_OUTS == 1) begin
          state_d = RUN;
        end else begin
          state_d = RELEASE;
          cnt_d   = STEP_LOAD;
          idx_d   = IW'(1);
        end
      end
    end
  end

  // In RELEASE, idx is the lowest bit still held, so everything below it is already released.
  always_comb begin
    out_d   = '1;
    ready_d = 1'b0;
    case (state_d)
      RELEASE: begin
        for (int i = 0; i < NUM_OUTS; i++) out_d[i] = (i >= int'(idx_d));
      end
      RUN: begin
        out_d   = '0;
        ready_d = 1'b1;
      end
      default: begin
        out_d   = '1;
        ready_d = 1'b0;
      end
    endcase
  end

  assign out   = out_q;
  assign ready = ready_q;

endmodule
